// File: rtl/capa_pkg.sv
// Shared definitions for the transaction-layer traffic generator/checker:
// FSM states, word-field helper and the no-progress watchdog limit.
package capa_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INIT,
        ST_REL,
        ST_SEND,
        ST_DRAIN,
        ST_READ,
        ST_CHK,
        ST_FIN
    } capa_state_t;

    // Words are {dest, payload}; payload takes whatever the dest field leaves.
    function automatic int pay_w(input int data_w, input int dest_w);
        return data_w - dest_w;
    endfunction

    localparam int WDOG_W = 10;
    localparam logic [WDOG_W-1:0] WDOG_LIMIT = 10'd1023;

endpackage

// File: rtl/verificador_canal.sv
// Per-output-FIFO checker: registers the pop, then compares the word that
// appears next cycle against {CH, seq_rx}.
// Ports: clk, reset (async, low), clr (restart sequence), pop, data,
//        checked (word compared this cycle), mismatch (compare failed).
module verificador_canal
    import capa_pkg::*;
#(
    parameter int DATA_W = 12,
    parameter int DEST_W = 2,
    parameter int CH     = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic              pop,
    input  logic [DATA_W-1:0] data,
    output logic              checked,
    output logic              mismatch
);

    localparam int PAY_W = pay_w(DATA_W, DEST_W);
    localparam logic [DEST_W-1:0] DEST = CH[DEST_W-1:0];

    logic             pop_q;
    logic [PAY_W-1:0] seq_rx;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pop_q  <= 1'b0;
            seq_rx <= '0;
        end else if (clr) begin
            pop_q  <= 1'b0;
            seq_rx <= '0;
        end else begin
            pop_q <= pop;
            // Advance even on a bad word so later words resync.
            if (pop_q)
                seq_rx <= seq_rx + 1'b1;
        end
    end

    assign checked  = pop_q;
    assign mismatch = pop_q && (data != {DEST, seq_rx});

endmodule

// File: rtl/generador_verificador_capa.sv
// Traffic generator and checker for the transaction layer: programs thresholds,
// pulses init, streams round-robin words, drains and checks every output FIFO,
// then reads back and audits the word counters.
// Inputs : clk, reset (async, low), start, n_words, cfg_umbral_*, almost_full_in,
//          empty_azul, data_out_azul, idle, salida_contador, valid_contador.
// Outputs: FIFO_in, PUSH, pop_fifo_azules, umbral_*, init, req, idx,
//          done, error, err_count.
module generador_verificador_capa
    import capa_pkg::*;
#(
    parameter int DATA_W = 12,
    parameter int N_CHAN = 4,
    parameter int DEST_W = 2,
    parameter int UMB_W  = 3,
    parameter int CNT_W  = 5,
    parameter int NW_W   = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [NW_W-1:0]          n_words,
    input  logic [UMB_W-1:0]         cfg_umbral_bajo,
    input  logic [UMB_W-1:0]         cfg_umbral_alto,
    input  logic                     almost_full_in,
    input  logic [N_CHAN-1:0]        empty_azul,
    input  logic [N_CHAN*DATA_W-1:0] data_out_azul,
    input  logic                     idle,
    input  logic [CNT_W-1:0]         salida_contador,
    input  logic                     valid_contador,
    output logic [DATA_W-1:0]        FIFO_in,
    output logic                     PUSH,
    output logic [N_CHAN-1:0]        pop_fifo_azules,
    output logic [UMB_W-1:0]         umbral_bajo,
    output logic [UMB_W-1:0]         umbral_alto,
    output logic                     init,
    output logic                     req,
    output logic [2:0]               idx,
    output logic                     done,
    output logic                     error,
    output logic [7:0]               err_count
);

    localparam int PAY_W = pay_w(DATA_W, DEST_W);
    localparam int RX_W  = NW_W + 1;
    localparam int PC_W  = $clog2(N_CHAN + 1);
    localparam int EC_W  = 8;
    localparam logic [2:0] LAST_IDX = 3'(N_CHAN);

    capa_state_t       state;
    logic [NW_W-1:0]   nw_q;
    logic [NW_W-1:0]   tx_left;
    logic [DEST_W-1:0] tx_dest;
    logic [PAY_W-1:0]  seq_tx [N_CHAN];
    logic [RX_W-1:0]   rx_cnt;
    logic [WDOG_W-1:0] wdog;
    logic              icnt;
    logic              rd_gap;
    logic [CNT_W-1:0]  cnt_q [N_CHAN+1];

    logic [N_CHAN-1:0] chk_v;
    logic [N_CHAN-1:0] mis_v;
    logic [PC_W-1:0]   n_chk;
    logic [PC_W-1:0]   n_mis;
    logic [CNT_W-1:0]  sum;
    logic              streaming;
    logic              progress;
    logic              wd_fire;
    logic              chk_fail;
    logic [EC_W:0]     err_add;
    logic [EC_W:0]     err_sum;

    assign streaming = (state == ST_SEND) || (state == ST_DRAIN);
    assign PUSH = (state == ST_SEND) && !almost_full_in && (tx_left != '0);
    assign pop_fifo_azules = streaming ? ~empty_azul : '0;
    assign FIFO_in = {tx_dest, seq_tx[tx_dest]};
    assign progress = PUSH || (|pop_fifo_azules);
    assign wd_fire = streaming && !progress && (wdog == WDOG_LIMIT);

    for (genvar c = 0; c < N_CHAN; c++) begin : g_chk
        verificador_canal #(
            .DATA_W(DATA_W),
            .DEST_W(DEST_W),
            .CH    (c)
        ) u_chk (
            .clk     (clk),
            .reset   (reset),
            .clr     (state == ST_INIT),
            .pop     (pop_fifo_azules[c]),
            .data    (data_out_azul[c*DATA_W +: DATA_W]),
            .checked (chk_v[c]),
            .mismatch(mis_v[c])
        );
    end

    always_comb begin
        n_chk = '0;
        n_mis = '0;
        sum   = '0;
        for (int c = 0; c < N_CHAN; c++) begin
            n_chk = n_chk + PC_W'(chk_v[c]);
            n_mis = n_mis + PC_W'(mis_v[c]);
            sum   = sum + cnt_q[c];
        end
    end

    // Total is compared modulo the readback width, same as the hardware counter.
    assign chk_fail = (state == ST_CHK) && (sum != cnt_q[N_CHAN]);
    assign err_add  = (EC_W+1)'(n_mis) + (EC_W+1)'(wd_fire)
                    + (EC_W+1)'(chk_fail);
    assign err_sum  = {1'b0, err_count} + err_add;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= ST_IDLE;
            nw_q        <= '0;
            tx_left     <= '0;
            tx_dest     <= '0;
            rx_cnt      <= '0;
            wdog        <= '0;
            icnt        <= 1'b0;
            rd_gap      <= 1'b0;
            umbral_bajo <= '0;
            umbral_alto <= '0;
            init        <= 1'b0;
            req         <= 1'b0;
            idx         <= '0;
            done        <= 1'b0;
            error       <= 1'b0;
            err_count   <= '0;
            for (int c = 0; c < N_CHAN; c++)
                seq_tx[c] <= '0;
            for (int i = 0; i <= N_CHAN; i++)
                cnt_q[i] <= '0;
        end else begin
            if (err_add != '0) begin
                error     <= 1'b1;
                err_count <= err_sum[EC_W] ? '1 : err_sum[EC_W-1:0];
            end
            rx_cnt <= rx_cnt + RX_W'(n_chk);

            unique case (state)
                ST_IDLE: begin
                    if (start) begin
                        nw_q        <= n_words;
                        tx_left     <= n_words;
                        done        <= 1'b0;
                        error       <= 1'b0;
                        err_count   <= '0;
                        init        <= 1'b1;
                        umbral_bajo <= cfg_umbral_bajo;
                        umbral_alto <= cfg_umbral_alto;
                        icnt        <= 1'b0;
                        state       <= ST_INIT;
                    end
                end
                ST_INIT: begin
                    tx_dest <= '0;
                    rx_cnt  <= '0;
                    for (int c = 0; c < N_CHAN; c++)
                        seq_tx[c] <= '0;
                    icnt <= 1'b1;
                    if (icnt) begin
                        init  <= 1'b0;
                        state <= ST_REL;
                    end
                end
                ST_REL: begin
                    if (idle) begin
                        wdog <= '0;
                        if (nw_q == '0) begin
                            req    <= 1'b1;
                            idx    <= '0;
                            rd_gap <= 1'b0;
                            state  <= ST_READ;
                        end else begin
                            state <= ST_SEND;
                        end
                    end
                end
                ST_SEND, ST_DRAIN: begin
                    if (PUSH) begin
                        tx_dest         <= tx_dest + 1'b1;
                        seq_tx[tx_dest] <= seq_tx[tx_dest] + 1'b1;
                        tx_left         <= tx_left - 1'b1;
                    end
                    wdog <= progress ? '0 : wdog + 1'b1;
                    if (wd_fire || ((state == ST_DRAIN)
                        && (rx_cnt >= {1'b0, nw_q}) && (&empty_azul))) begin
                        req    <= 1'b1;
                        idx    <= '0;
                        rd_gap <= 1'b0;
                        state  <= ST_READ;
                    end else if ((state == ST_SEND) && PUSH
                                 && (tx_left == NW_W'(1))) begin
                        state <= ST_DRAIN;
                    end
                end
                ST_READ: begin
                    // Each counter: hold req until valid, then one idle cycle.
                    if (!rd_gap) begin
                        if (valid_contador) begin
                            cnt_q[idx] <= salida_contador;
                            req        <= 1'b0;
                            rd_gap     <= 1'b1;
                        end
                    end else begin
                        rd_gap <= 1'b0;
                        if (idx == LAST_IDX) begin
                            state <= ST_CHK;
                        end else begin
                            idx <= idx + 1'b1;
                            req <= 1'b1;
                        end
                    end
                end
                ST_CHK: state <= ST_FIN;
                ST_FIN: begin
                    done  <= 1'b1;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_generador_verificador_capa.sv
// Bench for generador_verificador_capa: behavioural transaction layer with
// output FIFOs and counters, plus a word scoreboard on the push side.
module tb_generador_verificador_capa;

    localparam int DW     = 12;
    localparam int N      = 4;
    localparam int DEST_W = 2;
    localparam int PAY_W  = DW - DEST_W;
    localparam int UW     = 3;
    localparam int CW     = 5;
    localparam int NWW    = 8;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            start;
    logic [NWW-1:0]  n_words;
    logic [UW-1:0]   cfg_bajo;
    logic [UW-1:0]   cfg_alto;
    logic            almost_full_in;
    logic [N-1:0]    empty_azul;
    logic [N*DW-1:0] dout;
    logic            idle;
    logic [CW-1:0]   salida_contador;
    logic            valid_contador;
    logic [DW-1:0]   FIFO_in;
    logic            PUSH;
    logic [N-1:0]    pop_fifo_azules;
    logic [UW-1:0]   umbral_bajo;
    logic [UW-1:0]   umbral_alto;
    logic            init;
    logic            req;
    logic [2:0]      idx;
    logic            done;
    logic            error;
    logic [7:0]      err_count;

    bit corrupt;
    bit bad4;
    bit hold;

    int checks = 0;
    int errors = 0;
    int push_cnt = 0;
    int pop_cnt = 0;
    int stall_viol = 0;
    int init_cyc = 0;

    logic [DW-1:0] sb [$];
    logic [DW-1:0] q [N][$];
    int mcnt [N];
    int mtot;

    always #5 clk = ~clk;

    generador_verificador_capa #(
        .DATA_W(DW), .N_CHAN(N), .DEST_W(DEST_W),
        .UMB_W(UW), .CNT_W(CW), .NW_W(NWW)
    ) dut (
        .clk            (clk),
        .reset          (rst_n),
        .start          (start),
        .n_words        (n_words),
        .cfg_umbral_bajo(cfg_bajo),
        .cfg_umbral_alto(cfg_alto),
        .almost_full_in (almost_full_in),
        .empty_azul     (empty_azul),
        .data_out_azul  (dout),
        .idle           (idle),
        .salida_contador(salida_contador),
        .valid_contador (valid_contador),
        .FIFO_in        (FIFO_in),
        .PUSH           (PUSH),
        .pop_fifo_azules(pop_fifo_azules),
        .umbral_bajo    (umbral_bajo),
        .umbral_alto    (umbral_alto),
        .init           (init),
        .req            (req),
        .idx            (idx),
        .done           (done),
        .error          (error),
        .err_count      (err_count)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // Ideal transaction layer: routes by dest, registered FIFO read,
    // per-channel and total counters, one-cycle valid readback.
    always @(posedge clk or negedge rst_n) begin
        logic [DW-1:0] w;
        int d;
        int v;
        if (!rst_n) begin
            for (int c = 0; c < N; c++) begin
                q[c].delete();
                mcnt[c] = 0;
            end
            mtot = 0;
            dout <= '0;
            empty_azul <= '1;
            idle <= 1'b0;
            valid_contador <= 1'b0;
            salida_contador <= '0;
        end else begin
            idle <= !init;
            if (init) begin
                for (int c = 0; c < N; c++) begin
                    q[c].delete();
                    mcnt[c] = 0;
                end
                mtot = 0;
            end
            for (int c = 0; c < N; c++) begin
                if (pop_fifo_azules[c] && q[c].size() != 0) begin
                    dout[c*DW +: DW] <= q[c].pop_front();
                    pop_cnt++;
                end
            end
            if (PUSH) begin
                w = FIFO_in;
                d = int'(w[DW-1 -: DEST_W]);
                if (corrupt && d == 2 && mcnt[2] == 1)
                    w[PAY_W-1:0] = PAY_W'(5);
                q[d].push_back(w);
                mcnt[d]++;
                mtot++;
            end
            for (int c = 0; c < N; c++)
                empty_azul[c] <= hold || (q[c].size() == 0);
            if (req && !valid_contador) begin
                v = (int'(idx) < N) ? mcnt[idx] : mtot;
                if (bad4 && int'(idx) == N)
                    v = 15;
                salida_contador <= CW'(v);
                valid_contador <= 1'b1;
            end else begin
                valid_contador <= 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (init)
                init_cyc++;
            if (PUSH) begin
                push_cnt++;
                if (almost_full_in)
                    stall_viol++;
                chk("push_expected", sb.size() != 0, 1'b1);
                if (sb.size() != 0)
                    chk("word", FIFO_in, sb.pop_front());
            end
        end
    end

    function automatic logic [DW-1:0] word(input int i);
        logic [DEST_W-1:0] d;
        logic [PAY_W-1:0] p;
        d = DEST_W'(i % N);
        p = PAY_W'(i / N);
        return {d, p};
    endfunction

    task automatic kick(input int n);
        for (int i = 0; i < n; i++)
            sb.push_back(word(i));
        @(posedge clk); #1;
        n_words = NWW'(n);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic run(input string tag, input int n, input bit stall,
                       input bit corr, input bit b4, input bit hld,
                       input int exp_err);
        int pbase;
        int obase;
        int sbase;
        int ibase;
        corrupt = corr;
        bad4 = b4;
        hold = hld;
        pbase = push_cnt;
        obase = pop_cnt;
        sbase = stall_viol;
        ibase = init_cyc;
        kick(n);
        fork
            begin
                int k = 0;
                if (stall) begin
                    while (push_cnt - pbase < 5 && k < 500) begin
                        @(posedge clk);
                        k++;
                    end
                    #1 almost_full_in = 1'b1;
                    repeat (10) @(posedge clk);
                    #1 almost_full_in = 1'b0;
                end
            end
            begin
                int t = 0;
                while (done !== 1'b1 && t < 4000) begin
                    @(posedge clk); #1;
                    t++;
                end
            end
        join
        chk({tag, "_done"}, done, 1'b1);
        chk({tag, "_error"}, error, exp_err != 0);
        chk({tag, "_err_count"}, err_count, exp_err);
        chk({tag, "_pushes"}, push_cnt - pbase, n);
        chk({tag, "_sb_left"}, sb.size(), 0);
        chk({tag, "_push_in_stall"}, stall_viol - sbase, 0);
        chk({tag, "_init_cycles"}, init_cyc - ibase, 2);
        chk({tag, "_umbral_bajo"}, umbral_bajo, cfg_bajo);
        chk({tag, "_umbral_alto"}, umbral_alto, cfg_alto);
        if (!hld)
            chk({tag, "_popped"}, pop_cnt - obase, n);
    endtask

    function automatic logic [63:0] outs();
        return 64'({FIFO_in, PUSH, pop_fifo_azules, umbral_bajo,
                    umbral_alto, init, req, idx, done, error, err_count});
    endfunction

    initial begin
        int pbase;
        int k;
        rst_n = 1'b0;
        start = 1'b0;
        n_words = '0;
        cfg_bajo = 3'd2;
        cfg_alto = 3'd6;
        almost_full_in = 1'b0;
        corrupt = 1'b0;
        bad4 = 1'b0;
        hold = 1'b0;
        repeat (3) @(posedge clk);
        #1 chk("reset_outputs", outs(), 64'd0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        run("basic", 16, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        run("stall", 16, 1'b1, 1'b0, 1'b0, 1'b0, 0);
        run("corrupt", 16, 1'b0, 1'b1, 1'b0, 1'b0, 1);
        run("bad_total", 16, 1'b0, 1'b0, 1'b1, 1'b0, 1);
        run("zero", 0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        cfg_bajo = 3'd1;
        cfg_alto = 3'd7;
        run("odd_count", 7, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        run("watchdog", 16, 1'b0, 1'b0, 1'b0, 1'b1, 1);

        corrupt = 1'b0;
        bad4 = 1'b0;
        hold = 1'b1;
        pbase = push_cnt;
        kick(16);
        k = 0;
        while (push_cnt - pbase < 16 && k < 300) begin
            @(posedge clk);
            k++;
        end
        chk("rst_reached_drain", push_cnt - pbase, 16);
        repeat (5) @(posedge clk);
        #3 rst_n = 1'b0;
        #1 chk("rst_mid_outputs", outs(), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        hold = 1'b0;
        run("after_reset", 16, 1'b0, 1'b0, 1'b0, 1'b0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/generador_verificador_capa.md
Name: generador_verificador_capa

Overview:
- Synthesizable, parametrised traffic generator and checker for the transaction layer.
- Drives the main input FIFO and the threshold/init configuration, and drains all N_CHAN output ("azul") FIFOs.
- Checks every popped word for correct destination and order, then audits the word counters.
- Replaces hand-sequenced bench stimulus; usable in simulation and on FPGA as a self-test block.

Parameters:
- DATA_W, 12, word width; the top DEST_W bits are the destination, the rest are payload.
- N_CHAN, 4, number of output FIFOs / destinations (power of 2, ≥2).
- DEST_W, 2, log2(N_CHAN).
- UMB_W, 3, threshold width.
- CNT_W, 5, counter readback width.
- NW_W, 8, width of the word-count request.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; launches a run (ignored unless in IDLE).
- n_words  in  NW_W  words per run, sampled on start.
- cfg_umbral_bajo  in  UMB_W  almost-empty threshold to program.
- cfg_umbral_alto  in  UMB_W  almost-full threshold to program.
- almost_full_in  in  1  main input FIFO almost-full.
- empty_azul  in  N_CHAN  per-output-FIFO empty.
- data_out_azul  in  N_CHAN*DATA_W  output FIFO data, channel c at [c*DATA_W +: DATA_W].
- idle  in  1  transaction-layer FSM idle.
- salida_contador  in  CNT_W  counter readback.
- valid_contador  in  1  readback valid.
- FIFO_in  out  DATA_W  word to main FIFO.
- PUSH  out  1  push strobe.
- pop_fifo_azules  out  N_CHAN  pop strobes.
- umbral_bajo  out  UMB_W  threshold to DUT.
- umbral_alto  out  UMB_W  threshold to DUT.
- init  out  1  DUT init.
- req  out  1  counter request.
- idx  out  3  counter index.
- done  out  1  run complete (level, held until next start).
- error  out  1  sticky mismatch flag.
- err_count  out  8  saturating mismatch count.

Behaviour:
- Reset (reset=0, async): all outputs 0, including FIFO_in, thresholds, err_count and done. Per-channel sequence counters cleared. FSM to IDLE.
- Word format: FIFO_in = {dest, payload}. dest = tx_idx mod N_CHAN (round-robin). payload = seq_tx[dest], the per-destination count, which wraps modulo 2^(DATA_W-DEST_W).
- FSM states:
  - IDLE: wait for start.
  - INIT: init=1 for 2 cycles; umbral_* driven from cfg_*.
  - REL: init=0; wait until idle=1.
  - SEND: PUSH=1 on each cycle with almost_full_in=0 and words remaining. PUSH=0 while almost_full_in=1, with no word lost or repeated. Draining runs in parallel.
  - DRAIN: entered when all n_words are pushed; stays until all received words equal n_words and empty_azul is all 1s.
  - READ: for i=0..N_CHAN, assert req=1 and idx=i, wait for valid_contador, latch the value, then deassert req for 1 cycle.
  - CHK: compare the sum of counters 0..N_CHAN-1 (modulo 2^CNT_W) with counter N_CHAN; on mismatch, raise error and increment err_count.
  - FIN: done=1, return to IDLE.
- Pop rule: pop_fifo_azules[c]=1 in any SEND/DRAIN cycle where empty_azul[c]=0. Data is valid the cycle after the pop; the checker compares on the registered pop.
- Check rule for channel c: dest field must equal c and payload must equal seq_rx[c]. seq_rx[c] increments on every checked word, even on mismatch, so the channel resyncs.
- Multiple channels popping in the same cycle are each checked. err_count increments by the number of mismatches that cycle and saturates at 255.
- n_words=0: skip SEND and DRAIN, go straight to READ.
- start during a run: ignored.
- Reset mid-run: immediate abort, all state cleared, no partial done.
- Watchdog: 1024 cycles with no push/pop progress in SEND/DRAIN → error=1, err_count+1, jump to READ.

Decomposition:
- Package capa_pkg holds:
  - FSM state enum;
  - word field macros/localparams (DEST_W, payload width);
  - watchdog limit constant.
- Sub-module verificador_canal, instantiated N_CHAN times: registered pop, seq_rx counter, compare, mismatch pulse.

Test Plan:
- Reset release, start, n_words=16, cfg 2/6, ideal DUT model → 4 words per channel with payloads 0..3; counters read 4,4,4,4,16; done=1, error=0, err_count=0.
- almost_full_in held 1 for 10 cycles mid-SEND → PUSH=0 during the stall; all 16 words delivered exactly once; error=0.
- Model corrupts channel 2's second word (payload 5 instead of 1) → error=1, err_count=1; subsequent channel 2 words check clean.
- Counter 4 model returns 15 instead of 16 → CHK flags error, err_count=1.
- n_words=0 → INIT, READ, FIN with no PUSH pulses; done=1.
- reset=0 asserted in DRAIN → all outputs 0 within the same cycle, FSM IDLE; a new start then runs clean.
